// File: rtl/xc_malu_pkg.sv
// rtl/xc_malu_pkg.sv - shared op/pw codes, uop indices and issue-stage states
package xc_malu_pkg;

  localparam logic [3:0] OP_DIV    = 4'd0;
  localparam logic [3:0] OP_DIVU   = 4'd1;
  localparam logic [3:0] OP_REM    = 4'd2;
  localparam logic [3:0] OP_REMU   = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_MULU   = 4'd5;
  localparam logic [3:0] OP_MULSU  = 4'd6;
  localparam logic [3:0] OP_CLMUL  = 4'd7;
  localparam logic [3:0] OP_PMUL   = 4'd8;
  localparam logic [3:0] OP_PCLMUL = 4'd9;
  localparam logic [3:0] OP_MADD   = 4'd10;
  localparam logic [3:0] OP_MSUB   = 4'd11;
  localparam logic [3:0] OP_MACC   = 4'd12;
  localparam logic [3:0] OP_MMUL   = 4'd13;
  localparam int         OP_NUM    = 14;

  localparam logic [2:0] PW_32 = 3'd0;
  localparam logic [2:0] PW_16 = 3'd1;
  localparam logic [2:0] PW_8  = 3'd2;
  localparam logic [2:0] PW_4  = 3'd3;
  localparam logic [2:0] PW_2  = 3'd4;
  localparam int         PW_NUM = 5;

  // Bit positions inside malu_uop, for wiring to the ALU's named uop_* ports
  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/xc_malu_issue_if.sv
// rtl/xc_malu_issue_if.sv - request, ALU-side and response signals of the issue stage
interface xc_malu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_pw;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;

  logic [31:0] malu_rs1;
  logic [31:0] malu_rs2;
  logic [31:0] malu_rs3;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic        malu_valid;
  logic        malu_flush;
  logic [63:0] malu_result;
  logic        malu_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3,
    output req_ready,
    output malu_rs1, malu_rs2, malu_rs3, malu_uop, malu_pw, malu_valid, malu_flush,
    input  malu_result, malu_ready,
    output rsp_valid, rsp_result, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3,
    input  req_ready,
    input  malu_rs1, malu_rs2, malu_rs3, malu_uop, malu_pw, malu_valid, malu_flush,
    output malu_result, malu_ready,
    input  rsp_valid, rsp_result, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/xc_malu_issue_decode.sv
// rtl/xc_malu_issue_decode.sv - op/pw code to one-hot ALU controls plus illegal flag
module xc_malu_issue_decode
  import xc_malu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [2:0]  pw,
  output logic [13:0] uop,
  output logic [4:0]  pw_oh,
  output logic        illegal
);

  logic legal_op;
  logic legal_pw;

  assign legal_op = (op <= OP_MMUL);
  assign legal_pw = (pw <= PW_2);

  // Illegal codes decode to all-zero so nothing reaches the ALU even if latched
  assign uop     = legal_op ? (14'd1 << op) : 14'd0;
  assign pw_oh   = legal_pw ? (5'd1 << pw) : 5'd0;
  assign illegal = !(legal_op && legal_pw);

endmodule

// File: rtl/xc_malu_issue.sv
// rtl/xc_malu_issue.sv - request sequencing, hold, timeout and kill in front of xc_malu
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter int TIMEOUT = 80,
  parameter int CW      = 7
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          kill,
  xc_malu_issue_if.slave bus
);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] rs1_q, rs2_q, rs3_q;
  logic [13:0] uop_q;
  logic [4:0]  pw_q;
  logic [63:0] result_q;
  logic        err_q;

  logic [13:0] dec_uop;
  logic [4:0]  dec_pw;
  logic        dec_illegal;
  logic        timeout;

  xc_malu_issue_decode u_decode (
    .op      (bus.req_op),
    .pw      (bus.req_pw),
    .uop     (dec_uop),
    .pw_oh   (dec_pw),
    .illegal (dec_illegal)
  );

  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      uop_q    <= '0;
      pw_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (kill) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            rs1_q <= bus.req_rs1;
            rs2_q <= bus.req_rs2;
            rs3_q <= bus.req_rs3;
            uop_q <= dec_uop;
            pw_q  <= dec_pw;
            cnt   <= '0;
            if (dec_illegal) begin
              state    <= ST_RESP;
              err_q    <= 1'b1;
              result_q <= '0;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          // A ready ALU wins over a timeout landing in the same cycle
          if (bus.malu_ready) begin
            result_q <= bus.malu_result;
            err_q    <= 1'b0;
            state    <= ST_RESP;
          end else if (timeout) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE) && !kill;
  assign bus.malu_valid = (state == ST_RUN) && !kill;
  // Flush is low only while an operation is genuinely in flight
  assign bus.malu_flush = !resetn || kill || (state != ST_RUN) || bus.malu_ready || timeout;
  assign bus.rsp_valid  = (state == ST_RESP) && !kill;

  assign bus.malu_rs1   = rs1_q;
  assign bus.malu_rs2   = rs2_q;
  assign bus.malu_rs3   = rs3_q;
  assign bus.malu_uop   = uop_q;
  assign bus.malu_pw    = pw_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_xc_malu_issue.sv
// tb/tb_xc_malu_issue.sv - directed self-checking bench for xc_malu_issue
module tb_xc_malu_issue;

  logic clock;
  logic resetn;
  logic kill;
  xc_malu_issue_if bus ();

  xc_malu_issue #(.TIMEOUT(80), .CW(7)) dut (
    .clock  (clock),
    .resetn (resetn),
    .kill   (kill),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU model: raises ready on the lat-th consecutive valid cycle; lat==0 never
  int          lat;
  int          run_cnt;
  logic [63:0] alu_res;

  always @(posedge clock) begin
    if (!bus.malu_valid || bus.malu_ready) run_cnt <= 0;
    else run_cnt <= run_cnt + 1;
  end
  assign bus.malu_ready  = bus.malu_valid && (lat != 0) && (run_cnt == lat - 1);
  assign bus.malu_result = alu_res;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else pass_cnt++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic accept(input logic [3:0] op, input logic [2:0] pw,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    bus.req_op = op; bus.req_pw = pw;
    bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rs3 = c;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [13:0] uop_e, input logic [4:0] pw_e, input logic [31:0] rs1_e,
                        output int runs, output bit held_ok, output bit last_flush, output bit early_flush);
    runs = 0; held_ok = 1'b1; last_flush = 1'b0; early_flush = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.malu_valid) break;
      runs++;
      if (bus.malu_uop !== uop_e || bus.malu_pw !== pw_e || bus.malu_rs1 !== rs1_e) held_ok = 1'b0;
      if (i > 0 && last_flush) early_flush = 1'b1;
      last_flush = bus.malu_flush;
      step();
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  int runs;
  bit held_ok, last_flush, early_flush;
  bit stable_ok, seen_rsp;

  initial begin
    resetn = 1'b0; kill = 1'b0; lat = 0; alu_res = '0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_pw = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rs3 = '0; bus.rsp_ready = 1'b0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_flush", {63'd0, bus.malu_flush}, 64'd1);
    chk("rst_valid", {63'd0, bus.malu_valid}, 64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_rsp_result", bus.rsp_result, 64'd0);

    // mulu 0xFFFFFFFF * 2, ALU ready after 33 cycles
    lat = 33; alu_res = 64'h1_FFFF_FFFE;
    accept(4'd5, 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd0);
    run_op(14'h0020, 5'b00001, 32'hFFFF_FFFF, runs, held_ok, last_flush, early_flush);
    chk("mulu_runs", 64'(runs), 64'd33);
    chk("mulu_held", {63'd0, held_ok}, 64'd1);
    chk("mulu_flush_ready", {63'd0, last_flush}, 64'd1);
    chk("mulu_flush_early", {63'd0, early_flush}, 64'd0);
    chk("mulu_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("mulu_result", bus.rsp_result, 64'h1_FFFF_FFFE);
    chk("mulu_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("mulu_req_ready", {63'd0, bus.req_ready}, 64'd0);
    handshake();
    chk("mulu_idle", {63'd0, bus.req_ready}, 64'd1);

    // illegal op 15 then illegal pw 6
    accept(4'd15, 3'd0, 32'd1, 32'd1, 32'd1);
    chk("ilop_valid", {63'd0, bus.malu_valid}, 64'd0);
    chk("ilop_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("ilop_err", {63'd0, bus.rsp_err}, 64'd1);
    chk("ilop_result", bus.rsp_result, 64'd0);
    handshake();
    accept(4'd4, 3'd6, 32'd1, 32'd1, 32'd1);
    chk("ilpw_valid", {63'd0, bus.malu_valid}, 64'd0);
    chk("ilpw_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("ilpw_err", {63'd0, bus.rsp_err}, 64'd1);
    handshake();

    // timeout: ALU never ready
    lat = 0;
    accept(4'd4, 3'd1, 32'd7, 32'd9, 32'd0);
    run_op(14'h0010, 5'b00010, 32'd7, runs, held_ok, last_flush, early_flush);
    chk("to_runs", 64'(runs), 64'd80);
    chk("to_flush_last", {63'd0, last_flush}, 64'd1);
    chk("to_flush_early", {63'd0, early_flush}, 64'd0);
    chk("to_err", {63'd0, bus.rsp_err}, 64'd1);
    chk("to_result", bus.rsp_result, 64'd0);
    handshake();

    // ready on the same cycle the timeout would fire
    lat = 80; alu_res = 64'h0000_ABCD_1234_5678;
    accept(4'd7, 3'd2, 32'd3, 32'd5, 32'd0);
    run_op(14'h0080, 5'b00100, 32'd3, runs, held_ok, last_flush, early_flush);
    chk("rt_runs", 64'(runs), 64'd80);
    chk("rt_err", {63'd0, bus.rsp_err}, 64'd0);
    chk("rt_result", bus.rsp_result, 64'h0000_ABCD_1234_5678);
    handshake();

    // kill on the 5th RUN cycle of a div
    lat = 0;
    accept(4'd0, 3'd0, 32'd100, 32'd7, 32'd0);
    repeat (4) step();
    chk("kill_pre_flush", {63'd0, bus.malu_flush}, 64'd0);
    kill = 1'b1;
    #1;
    chk("kill_flush", {63'd0, bus.malu_flush}, 64'd1);
    chk("kill_valid", {63'd0, bus.malu_valid}, 64'd0);
    step();
    kill = 1'b0;
    #1;
    chk("kill_idle", {63'd0, bus.req_ready}, 64'd1);
    seen_rsp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid) seen_rsp = 1'b1;
      step();
    end
    chk("kill_no_rsp", {63'd0, seen_rsp}, 64'd0);

    // madd with 10 cycles of back-pressure
    lat = 3; alu_res = 64'h0000_0001_0000_0003;
    accept(4'd10, 3'd0, 32'd1, 32'd2, 32'd3);
    chk("madd_valid", {63'd0, bus.malu_valid}, 64'd1);
    run_op(14'h0400, 5'b00001, 32'd1, runs, held_ok, last_flush, early_flush);
    chk("madd_runs", 64'(runs), 64'd3);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'h0000_0001_0000_0003 ||
          bus.req_ready !== 1'b0 || bus.rsp_err !== 1'b0) stable_ok = 1'b0;
      step();
    end
    chk("bp_stable", {63'd0, stable_ok}, 64'd1);
    handshake();
    chk("bp_idle", {63'd0, bus.req_ready}, 64'd1);
    chk("bp_rsp_done", {63'd0, bus.rsp_valid}, 64'd0);

    // kill while a response is pending
    lat = 1; alu_res = 64'd42;
    accept(4'd4, 3'd0, 32'd6, 32'd7, 32'd0);
    run_op(14'h0010, 5'b00001, 32'd6, runs, held_ok, last_flush, early_flush);
    chk("kresp_pending", {63'd0, bus.rsp_valid}, 64'd1);
    kill = 1'b1;
    #1;
    chk("kresp_masked", {63'd0, bus.rsp_valid}, 64'd0);
    step();
    kill = 1'b0;
    #1;
    chk("kresp_idle", {63'd0, bus.req_ready}, 64'd1);
    chk("kresp_gone", {63'd0, bus.rsp_valid}, 64'd0);

    // request presented with kill in IDLE is refused
    kill = 1'b1;
    bus.req_op = 4'd4; bus.req_pw = 3'd0; bus.req_valid = 1'b1;
    #1;
    chk("kidle_ready", {63'd0, bus.req_ready}, 64'd0);
    step();
    bus.req_valid = 1'b0; kill = 1'b0;
    #1;
    chk("kidle_no_run", {63'd0, bus.malu_valid}, 64'd0);
    chk("kidle_still_idle", {63'd0, bus.req_ready}, 64'd1);

    // reset mid-operation
    lat = 0;
    accept(4'd1, 3'd0, 32'd9, 32'd3, 32'd0);
    repeat (2) step();
    resetn = 1'b0;
    #1;
    chk("mrst_flush", {63'd0, bus.malu_flush}, 64'd1);
    chk("mrst_valid", {63'd0, bus.malu_valid}, 64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("mrst_idle", {63'd0, bus.req_ready}, 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/xc_malu_issue.md
Name: xc_malu_issue

Overview:
- Issue/sequencing stage that sits directly upstream of the multi-cycle ALU (xc_malu).
- Accepts one request at a time from the execute pipeline on a valid/ready handshake and decodes the op and pack-width fields into the ALU's one-hot controls.
- Holds operands and ALU valid stable until the ALU reports ready, captures the 64-bit result, then flushes the ALU.
- Returns the result on a valid/ready response channel, with timeout and kill handling.

Parameters:
- TIMEOUT, 80, cycles in RUN without malu_ready before the request is aborted with rsp_err.
- CW, 7, width of the busy-cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- kill  in  1  pipeline flush; abandon any in-flight request
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  0 div, 1 divu, 2 rem, 3 remu, 4 mul, 5 mulu, 6 mulsu, 7 clmul, 8 pmul, 9 pclmul, 10 madd, 11 msub, 12 macc, 13 mmul; 14-15 illegal
- req_pw  in  3  0=32, 1=16, 2=8, 3=4, 4=2; 5-7 illegal
- req_rs1, req_rs2, req_rs3  in  32 each  source operands
- malu_rs1, malu_rs2, malu_rs3  out  32 each  registered operands to ALU
- malu_uop  out  14  one-hot uop; bit index equals req_op code
- malu_pw  out  5  {pw_2, pw_4, pw_8, pw_16, pw_32}, one-hot
- malu_valid  out  1  ALU inputs valid
- malu_flush  out  1  ALU state flush
- malu_result  in  64  ALU result
- malu_ready  in  1  ALU result ready
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  captured result
- rsp_err  out  1  illegal op/pw, or timeout

Behaviour:
- Clock and reset: one clock, clock. Reset resetn is asynchronous and active-low. All state flops reset asynchronously.
- Reset values: state=IDLE; operand, uop and pw registers=0; rsp_result=0; rsp_err=0; counter=0. This gives req_ready=1, malu_valid=0, malu_flush=1 and rsp_valid=0 out of reset.
- States: IDLE, RUN, RESP (binary-encoded; no others reachable).
- IDLE:
  - req_ready=1, malu_valid=0, malu_flush=1 (ALU is held clean while idle).
  - On req_valid, register operands and decoded uop/pw, and clear the counter.
  - Legal op and pw → RUN.
  - Illegal op or pw → RESP with rsp_err=1 and rsp_result=0; the ALU is never launched.
- RUN:
  - req_ready=0, malu_valid=1, operands/uop/pw held constant. The counter increments every cycle.
  - If malu_ready: capture malu_result into rsp_result, set rsp_err=0, assert malu_flush in the same cycle, next state RESP.
  - Else if counter==TIMEOUT-1: set rsp_err=1, rsp_result=0, malu_flush=1, next state RESP.
  - Else: malu_flush=0.
- RESP:
  - rsp_valid=1, malu_valid=0, malu_flush=1, req_ready=0.
  - rsp_result and rsp_err hold until rsp_valid && rsp_ready, then → IDLE.
  - Back-pressure may last indefinitely.
- Minimum latency:
  - Request accepted at edge t0; RUN in cycle t0..t1.
  - A combinationally-ready ALU op gives malu_ready in the first RUN cycle, so rsp_valid is high in the cycle after edge t1.
  - Throughput is at most one request per 3 cycles; no accept in the same cycle as a response handshake.
- kill:
  - Highest priority in every state: malu_flush=1, malu_valid=0, next state IDLE, no response produced.
  - A request presented with kill in IDLE is not accepted; req_ready is forced to 0 while kill=1.
  - kill in RESP discards the pending response.
- Simultaneous malu_ready and timeout in the same cycle: ready wins; the result is captured with rsp_err=0.
- Reset mid-operation: immediate return to IDLE, with malu_flush=1 combinationally so the ALU's synchronous flush clears it.
- malu_uop and malu_pw are registered decodes, never combinational from req_*, so ALU inputs are glitch-free during RUN.

Decomposition:
- Shared package xc_malu_pkg:
  - op code localparams (OP_DIV..OP_MMUL, OP_NUM=14)
  - pw code localparams (PW_32..PW_2)
  - state encodings
  - uop bit-index constants used by the integration wiring to xc_malu's named uop_* ports
- One sub-module: xc_malu_issue_decode, purely combinational. Maps req_op/req_pw to malu_uop one-hot, malu_pw one-hot and an illegal flag. It is instantiated once and its outputs are registered in IDLE.

Test Plan:
- Reset, then idle: req_ready=1, malu_flush=1, malu_valid=0, rsp_valid=0, rsp_result=0.
- mulu with rs1=0xFFFFFFFF, rs2=2, ALU model ready after 33 cycles:
  - malu_uop=14'h0020, malu_pw=5'b00001 held for all 33 RUN cycles.
  - rsp_result=0x1_FFFFFFFE, rsp_err=0.
  - malu_flush=1 on the ready cycle.
- req_op=15 or req_pw=6: no malu_valid pulse; rsp_valid next cycle with rsp_err=1, rsp_result=0.
- ALU model never ready, TIMEOUT=80: exactly 80 RUN cycles, then rsp_err=1; malu_flush pulses on the 80th cycle.
- kill asserted on the 5th RUN cycle of a div: state IDLE next cycle, no rsp_valid ever, next request accepted normally.
- rsp_ready held low 10 cycles after madd result 0x0000_0001_0000_0003: rsp_valid and data stable for all 10 cycles, req_ready=0; handshake → IDLE.
